// File: rtl/fixed_point_accumulator.sv
// Sums ACC_LEN signed fixed-point samples into one WL-bit result with valid/ready on both sides.
// Define FXP_ACC_SATURATE_EN to clip the result (flagged on out_sat); otherwise the result wraps.
module fixed_point_accumulator #(
    parameter int WL      = 8,
    parameter int FL      = 2,
    parameter int ACC_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_data,
    output logic          out_sat
);

    localparam int AW = WL + $clog2(ACC_LEN) + 1;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ACC_LEN - 1);

    if (WL < 2 || ACC_LEN < 1 || FL < 0 || FL >= WL) begin : g_param_check
        $error("fixed_point_accumulator: illegal WL/FL/ACC_LEN");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WL-1:0]   res_data_q, res_data_d;
    logic            res_sat_q, res_sat_d;

    logic [AW-1:0]   sample_ext;
    logic [AW-1:0]   sum;
    logic [WL-1:0]   lim_data;
    logic            lim_sat;

    assign sample_ext = {{(AW-WL){in_data[WL-1]}}, in_data};
    assign sum        = acc_q + sample_ext;

`ifdef FXP_ACC_SATURATE_EN
    logic [AW-WL:0] sum_top;
    logic           sum_fits;

    // The sum fits in WL bits exactly when every bit above the WL-bit sign agrees with it.
    assign sum_top  = sum[AW-1:WL-1];
    assign sum_fits = (&sum_top) | ~(|sum_top);

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        lim_data = sum[WL-1:0];
        lim_sat  = 1'b0;
        if (!sum_fits) begin
            lim_sat  = 1'b1;
            lim_data = sum[AW-1] ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}};
        end
    end
`else
    assign lim_data = sum[WL-1:0];
    assign lim_sat  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_sat_d  = res_sat_q;
        case (state_q)
            ACCUM: begin
                // clear wins over a beat offered in the same cycle
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == LAST_CNT) begin
                        res_data_d = lim_data;
                        res_sat_d  = lim_sat;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: all state here is plain registers, so every one of them is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_sat_q  <= res_sat_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = res_data_q;
    assign out_sat   = res_sat_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Self-checking bench for fixed_point_accumulator (WL=8, FL=2, ACC_LEN=4): directed cases then
// randomized groups, scored against an integer-sum reference model.
module tb_fixed_point_accumulator;

    localparam int WL      = 8;
    localparam int FL      = 2;
    localparam int ACC_LEN = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_data;
    logic          out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: running integer sum of the current group and queue of {sat, data} results
    int            grp_sum = 0;
    int            grp_n   = 0;
    logic [WL:0]   exp_q[$];

    fixed_point_accumulator #(.WL(WL), .FL(FL), .ACC_LEN(ACC_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WL:0] limit(input int s);
        logic [WL:0] r;
        int smax;
        int smin;
        smax = (1 << (WL-1)) - 1;
        smin = -(1 << (WL-1));
        r = {1'b0, WL'(s)};
`ifdef FXP_ACC_SATURATE_EN
        if (s > smax)      r = {1'b1, WL'(smax)};
        else if (s < smin) r = {1'b1, WL'(smin)};
`endif
        return r;
    endfunction

    function automatic bit model_accept(input logic [WL-1:0] d);
        grp_sum += int'($signed(d));
        grp_n++;
        if (grp_n == ACC_LEN) begin
            exp_q.push_back(limit(grp_sum));
            grp_sum = 0;
            grp_n   = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        grp_sum = 0;
        grp_n   = 0;
        exp_q.delete();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [WL-1:0] d);
        bit fin;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        check("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        fin = model_accept(d);
        if (fin) begin
            check("latency_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end else begin
            check("no_early_out_valid", out_valid, 0);
        end
    endtask

    task automatic drain(input int stall);
        logic [WL:0] exp;
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        check("drain_out_valid", out_valid, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        // offered beats during the stall must not be consumed
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WL'($urandom);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_data", out_data, exp[WL-1:0]);
            tick();
        end
        in_valid = 1'b0;
        check("out_data", out_data, exp[WL-1:0]);
        check("out_sat", out_sat, exp[WL]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("back_to_accum_valid", out_valid, 0);
        check("back_to_accum_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // power-on reset
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);
        check("reset_out_sat", out_sat, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // four beats of 1.0 give 4.0
        repeat (ACC_LEN) feed(8'h04);
        drain(0);

        // same group with out_ready held high throughout
        out_ready = 1'b1;
        repeat (ACC_LEN) feed(8'h04);
        check("oready_hi_data", out_data, 8'h10);
        tick();
        check("oready_hi_accum", in_ready, 1);
        void'(exp_q.pop_front());
        out_ready = 1'b0;

        // positive and negative extremes
        repeat (ACC_LEN) feed(8'h7F);
        drain(0);
        repeat (ACC_LEN) feed(8'h80);
        drain(0);

        // long backpressure with beats offered
        repeat (ACC_LEN) feed(8'h13);
        drain(5);

        // clear together with a beat discards both the partial sum and that beat
        feed(8'h10);
        feed(8'h10);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h10;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        grp_sum  = 0;
        grp_n    = 0;
        repeat (ACC_LEN) feed(8'h01);
        check("clear_result_model", exp_q[0][WL-1:0], 8'h04);
        drain(0);

        // clear while a result is pending leaves it untouched
        repeat (ACC_LEN) feed(8'hF0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_hold_valid", out_valid, 1);
        check("clear_hold_data", out_data, exp_q[0][WL-1:0]);
        drain(1);

        // asynchronous reset mid-group, between clock edges
        feed(8'h22);
        feed(8'h22);
        #2 rst_n = 1'b0;
        #1;
        check("midgrp_rst_out_data", out_data, 0);
        check("midgrp_rst_in_ready", in_ready, 1);
        check("midgrp_rst_out_valid", out_valid, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (ACC_LEN) feed(8'h04);
        drain(0);

        // reset with a result pending drops it
        repeat (ACC_LEN) feed(8'h33);
        rst_n = 1'b0;
        #1;
        check("hold_rst_out_valid", out_valid, 0);
        check("hold_rst_out_sat", out_sat, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();

        // randomized groups with idle gaps and backpressure
        for (int g = 0; g < 20; g++) begin
            for (int i = 0; i < ACC_LEN; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                feed(WL'($urandom));
            end
            drain(int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
